we_regbank: RTL
===============

// Module: we_regbank
// PURPOSE
//   Parametrised, byte-enabled write-enable register bank: DEPTH entries of WIDTH bits.
//   Per-entry sticky write-lock, registered read port, and saturating count of accepted writes.
//   Holds configuration or state words written by a host/controller and read back by datapath logic.
// PARAMETERS
//   WIDTH   64  entry width in bits; multiple of 8, >= 8
//   DEPTH   8   number of entries; >= 2, need not be a power of 2
//   CNT_W   16  width of accepted-write counter
//   ADDR_W  $clog2(DEPTH)  derived, not overridable
//   BE_W    WIDTH/8        derived, not overridable
// PORTS
//   clk       in   1       rising-edge clock
//   rst_n     in   1       asynchronous active-low reset
//   wn        in   1       write request this cycle
//   waddr     in   ADDR_W  write entry index
//   wdata     in   WIDTH   write data
//   wbe       in   BE_W    byte enables; bit i covers wdata[8i+7:8i]
//   lock      in   1       set sticky lock on entry waddr, this cycle
//   ren       in   1       read request
//   raddr     in   ADDR_W  read entry index
//   rdata     out  WIDTH   read data, valid when rvalid
//   rvalid    out  1       one-cycle pulse, rdata valid
//   wr_err    out  1       one-cycle pulse: previous-cycle write rejected
//   wr_count  out  CNT_W   accepted writes since reset, saturating
//   locked    out  DEPTH   per-entry lock status
// BEHAVIOUR
//   Reset (async assert, sync release): all entries 0, locked 0, rdata 0, rvalid 0, wr_err 0, wr_count 0.
//   Write accepted iff wn & (waddr < DEPTH) & ~locked[waddr] & (wbe != 0).
//     On accept: entry[waddr] bytes with wbe=1 take wdata; other bytes hold. wr_count += 1, stops at all-ones.
//   Write rejected iff wn & (waddr >= DEPTH or locked[waddr]). Entry unchanged; wr_err=1 next cycle.
//   wn with wbe=0 on a valid, unlocked entry: no-op, not counted, no wr_err.
//   lock: locked[waddr] set at the clock edge if waddr < DEPTH. Cleared only by reset.
//     Out-of-range lock ignored.
//     lock & wn in the same cycle: the write is evaluated against the pre-edge lock state,
//     so the write is accepted if the entry was unlocked.
//   Read: ren registers entry[raddr] into rdata; rvalid=1 exactly one cycle later.
//     raddr >= DEPTH returns 0 with rvalid=1.
//     No ren: rvalid=0, rdata holds its last value.
//   Read/write same entry, same cycle: see CONFIGURATION.
//   Reset mid-operation: pending rvalid/wr_err are dropped; all state is cleared immediately.
// CONFIGURATION
//   WE_REGBANK_BYPASS_EN defined:
//     same-cycle accepted write to raddr is forwarded; rdata = byte-merge of old entry and wdata per wbe.
//   Undefined:
//     read-first; rdata = entry value before the write.
//   Rejected writes are never forwarded.
// STRUCTURE
//   Package we_pkg: BYTE_W=8 constant; default WIDTH/DEPTH/CNT_W localparams;
//     function be_merge(old, new, be) shared by the write path and the bypass path.
//   One sub-module we_be_merge (combinational WIDTH-bit byte merge), instantiated for write and bypass.
//   Storage is a flop array; no memory macros.
// TESTING
//   1 Reset, then ren raddr=3 -> next cycle rvalid=1, rdata=0; wr_count=0, locked=0.
//   2 wn waddr=2 wdata=64'h1122334455667788 wbe=8'h0F, then read 2 -> rdata=64'h0000000055667788, wr_count=1.
//   3 lock waddr=2, then wn waddr=2 wdata=all-ones wbe=8'hFF
//       -> wr_err=1 next cycle, read 2 unchanged, wr_count unchanged, locked[2]=1.
//   4 wn waddr=5 wbe=8'hFF wdata=64'hA5A5.. with ren raddr=5, same cycle
//       -> rdata=new data if WE_REGBANK_BYPASS_EN, else old data (0).
//   5 DEPTH=6: wn waddr=7 -> wr_err=1, no entry changes; ren raddr=7 -> rdata=0, rvalid=1.
//   6 CNT_W=2: 5 accepted writes -> wr_count=3 and holds;
//       assert rst_n low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/we_pkg.sv
// we_pkg: shared constants and the byte-lane merge helper for the
// we_regbank register bank. Optional feature macro used by the bank:
// WE_REGBANK_BYPASS_EN (same-cycle write-to-read forwarding).
package we_pkg;

  localparam int BYTE_W    = 8;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 16;

  // One byte lane of a byte-enabled merge: take the new byte when enabled.
  function automatic logic [BYTE_W-1:0] be_merge(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/we_be_merge.sv
// we_be_merge: combinational WIDTH-bit byte merge. Every byte lane whose
// enable is set takes new_i, all other lanes keep old_i.
module we_be_merge
  import we_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int BE_W  = WIDTH / BYTE_W
) (
  input  logic [WIDTH-1:0] old_i,
  input  logic [WIDTH-1:0] new_i,
  input  logic [BE_W-1:0]  be_i,
  output logic [WIDTH-1:0] merged_o
);

  // Lane-by-lane merge through the shared package helper.
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < BE_W; i++) begin
      merged_o[i*BYTE_W +: BYTE_W] = be_merge(old_i[i*BYTE_W +: BYTE_W],
                                              new_i[i*BYTE_W +: BYTE_W],
                                              be_i[i]);
    end
  end

endmodule

// File: rtl/we_regbank.sv
// we_regbank: DEPTH x WIDTH byte-enabled register bank with per-entry sticky
// write lock, registered read port and a saturating accepted-write counter.
// Optional feature macro: WE_REGBANK_BYPASS_EN. When defined, an accepted
// write to the entry being read in the same cycle is forwarded to rdata;
// otherwise the read returns the entry value from before the write.
//
// Handshake: there is no back-pressure. wn/lock/ren are single-cycle
// requests sampled at each rising edge; rvalid and wr_err are one-cycle
// pulses reporting on the request of the previous cycle.
module we_regbank
  import we_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int CNT_W  = DEF_CNT_W,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = WIDTH / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wn,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              lock,
  input  logic              ren,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              wr_err,
  output logic [CNT_W-1:0]  wr_count,
  output logic [DEPTH-1:0]  locked
);

  // DEPTH need not be a power of two, so indices are range-checked with
  // one extra bit of headroom.
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] locked_q, locked_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             wr_err_q, wr_err_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic             waddr_ok, raddr_ok;
  logic [WIDTH-1:0] w_old, r_old, w_merged, rd_word;
  logic             w_locked;
  logic             wr_accept, wr_reject;

  assign waddr_ok = {1'b0, waddr} < DEPTH_A;
  assign raddr_ok = {1'b0, raddr} < DEPTH_A;

  // Select the addressed write and read entries (out-of-range selects zero).
  always_comb begin
    w_old    = '0;
    r_old    = '0;
    w_locked = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == ADDR_W'(i)) begin
        w_old    = mem_q[i];
        w_locked = locked_q[i];
      end
      if (raddr == ADDR_W'(i)) begin
        r_old = mem_q[i];
      end
    end
  end

  // Writes are judged against the lock state from before this edge, so a
  // lock and a write arriving together still let the write through.
  assign wr_accept = wn & waddr_ok & ~w_locked & (|wbe);
  assign wr_reject = wn & (~waddr_ok | w_locked);

  we_be_merge #(.WIDTH(WIDTH)) u_wr_merge (
    .old_i    (w_old),
    .new_i    (wdata),
    .be_i     (wbe),
    .merged_o (w_merged)
  );

`ifdef WE_REGBANK_BYPASS_EN
  logic [WIDTH-1:0] r_merged;
  logic             rd_fwd;

  we_be_merge #(.WIDTH(WIDTH)) u_byp_merge (
    .old_i    (r_old),
    .new_i    (wdata),
    .be_i     (wbe),
    .merged_o (r_merged)
  );

  // Rejected writes never have wr_accept set, so they are never forwarded.
  assign rd_fwd  = wr_accept & (waddr == raddr);
  assign rd_word = raddr_ok ? (rd_fwd ? r_merged : r_old) : '0;
`else
  // Read-first: the read sees the entry as it was before any same-cycle write.
  assign rd_word = raddr_ok ? r_old : '0;
`endif

  // Next-state for storage, locks, read port, error pulse and counter.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_accept && (waddr == ADDR_W'(i))) begin
        mem_d[i] = w_merged;
      end
    end

    locked_d = locked_q;
    if (lock && waddr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr == ADDR_W'(i)) begin
          locked_d[i] = 1'b1;
        end
      end
    end

    rvalid_d = ren;
    rdata_d  = ren ? rd_word : rdata_q;
    wr_err_d = wr_reject;

    wr_count_d = wr_count_q;
    if (wr_accept && (wr_count_q != '1)) begin
      wr_count_d = wr_count_q + 1'b1;
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      locked_q   <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      wr_err_q   <= 1'b0;
      wr_count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      locked_q   <= locked_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      wr_err_q   <= wr_err_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign wr_err   = wr_err_q;
  assign wr_count = wr_count_q;
  assign locked   = locked_q;

endmodule
